// File: rtl/sp_ram_port_arbiter.sv
// Two-master (instruction m0 / data m1) round-robin front end for a single-port RAM with 1-cycle read data.
// Optional SP_RAM_ARB_CLEAR_ON_RESET_EN: zero every RAM word after reset before accepting requests.
module sp_ram_port_arbiter #(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic                    init_done_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  logic       accept;
  logic [1:0] gnt;
  logic       rr_ptr_q;
  logic [1:0] rvalid_q;
  logic [1:0] we_q;

`ifdef SP_RAM_ARB_CLEAR_ON_RESET_EN
  localparam int CNT_WIDTH = ADDR_WIDTH - 2;
  localparam logic [CNT_WIDTH-1:0] CLR_LAST = CNT_WIDTH'(RAM_SIZE / 4 - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                 clearing;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + CNT_WIDTH'(1);
      if (clr_cnt_q == CLR_LAST) state_d = READY;
    end
  end

  // Gate with reset so nothing is written or granted while reset is held.
  assign clearing    = (state_q == CLEAR) && rstn_i;
  assign accept      = (state_q == READY) && rstn_i;
  assign init_done_o = accept;
`else
  assign accept      = rstn_i;
  assign init_done_o = rstn_i;
`endif

  // Contended cycles go to rr_ptr; a lone requester always wins.
  always_comb begin
    gnt = 2'b00;
    if (accept) begin
      if (m0_req_i && m1_req_i) gnt = rr_ptr_q ? 2'b10 : 2'b01;
      else                      gnt = {m1_req_i, m0_req_i};
    end
  end

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
`ifdef SP_RAM_ARB_CLEAR_ON_RESET_EN
    if (clearing) begin
      ram_en_o   = 1'b1;
      ram_we_o   = 1'b1;
      ram_be_o   = '1;
      ram_addr_o = {clr_cnt_q, 2'b00};
    end else
`endif
    if (gnt[0]) begin
      ram_en_o    = 1'b1;
      ram_we_o    = m0_we_i;
      ram_be_o    = m0_be_i;
      ram_addr_o  = m0_addr_i & WORD_MASK;
      ram_wdata_o = m0_wdata_i;
    end else if (gnt[1]) begin
      ram_en_o    = 1'b1;
      ram_we_o    = m1_we_i;
      ram_be_o    = m1_be_i;
      ram_addr_o  = m1_addr_i & WORD_MASK;
      ram_wdata_o = m1_wdata_i;
    end
  end

  // we_q remembers writes so their response carries zero data instead of RAM output.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr_q <= 1'b0;
      rvalid_q <= 2'b00;
      we_q     <= 2'b00;
    end else begin
      rvalid_q <= gnt;
      we_q     <= gnt & {m1_we_i, m0_we_i};
      if (accept && m0_req_i && m1_req_i) rr_ptr_q <= ~rr_ptr_q;
    end
  end

  assign m0_rvalid_o = rvalid_q[0];
  assign m1_rvalid_o = rvalid_q[1];
  assign m0_rdata_o  = (rvalid_q[0] && !we_q[0]) ? ram_rdata_i : '0;
  assign m1_rdata_o  = (rvalid_q[1] && !we_q[1]) ? ram_rdata_i : '0;

  logic unused_be_width;
  assign unused_be_width = (BE_WIDTH == 0);

endmodule

// File: tb/tb_sp_ram_port_arbiter.sv
// Directed-vector bench for sp_ram_port_arbiter; exercises the clear sequence when
// SP_RAM_ARB_CLEAR_ON_RESET_EN is defined.
module tb_sp_ram_port_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = 4;
`ifdef SP_RAM_ARB_CLEAR_ON_RESET_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o;
  logic [AW-1:0] m0_addr_i;
  logic [BW-1:0] m0_be_i;
  logic [DW-1:0] m0_wdata_i, m0_rdata_o;
  logic          m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o;
  logic [AW-1:0] m1_addr_i;
  logic [BW-1:0] m1_be_i;
  logic [DW-1:0] m1_wdata_i, m1_rdata_o;
  logic          ram_en_o, ram_we_o, init_done_o;
  logic [AW-1:0] ram_addr_o;
  logic [BW-1:0] ram_be_o;
  logic [DW-1:0] ram_wdata_o, ram_rdata_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          m0_req; logic [AW-1:0] m0_addr; logic m0_we; logic [BW-1:0] m0_be; logic [DW-1:0] m0_wdata;
    logic          m1_req; logic [AW-1:0] m1_addr; logic m1_we; logic [BW-1:0] m1_be; logic [DW-1:0] m1_wdata;
    logic [DW-1:0] rdata;
    logic [1:0]    gnt; logic en; logic [AW-1:0] addr; logic we; logic [BW-1:0] be; logic [DW-1:0] wdata;
    logic [1:0]    rvalid; logic [DW-1:0] r0; logic [DW-1:0] r1;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  sp_ram_port_arbiter dut (
    .clk(clk), .rstn_i(rstn_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .init_done_o(init_done_o)
  );

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    m0_req_i = v.m0_req; m0_addr_i = v.m0_addr; m0_we_i = v.m0_we; m0_be_i = v.m0_be; m0_wdata_i = v.m0_wdata;
    m1_req_i = v.m1_req; m1_addr_i = v.m1_addr; m1_we_i = v.m1_we; m1_be_i = v.m1_be; m1_wdata_i = v.m1_wdata;
    ram_rdata_i = v.rdata;
  endtask

  task automatic idleInputs();
    m0_req_i = 1'b0; m0_addr_i = '0; m0_we_i = 1'b0; m0_be_i = '0; m0_wdata_i = '0;
    m1_req_i = 1'b0; m1_addr_i = '0; m1_we_i = 1'b0; m1_be_i = '0; m1_wdata_i = '0;
    ram_rdata_i = '0;
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic doReset();
    rstn_i = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
  endtask

  task automatic waitReady();
    int n = 0;
    #1;
    while (!init_done_o && n < 9000) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("wait_ready", n, 32'(init_done_o), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{0, 15'h0000, 0, 4'h0, 32'h0,        0, 15'h0000, 0, 4'h0, 32'h0,        32'h0,        2'b00, 0, 15'h0000, 0, 4'h0, 32'h0,        2'b00, 32'h0,        32'h0};
    vecs[1]  = '{1, 15'h0010, 0, 4'hF, 32'hAAAA0000, 0, 15'h0000, 0, 4'h0, 32'h0,        32'h0,        2'b01, 1, 15'h0010, 0, 4'hF, 32'hAAAA0000, 2'b00, 32'h0,        32'h0};
    vecs[2]  = '{0, 15'h0000, 0, 4'h0, 32'h0,        0, 15'h0000, 0, 4'h0, 32'h0,        32'hDEADBEEF, 2'b00, 0, 15'h0000, 0, 4'h0, 32'h0,        2'b01, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1, 15'h0100, 0, 4'hF, 32'h0,        1, 15'h0204, 0, 4'hF, 32'h0,        32'h0,        2'b01, 1, 15'h0100, 0, 4'hF, 32'h0,        2'b00, 32'h0,        32'h0};
    vecs[4]  = '{1, 15'h0100, 0, 4'hF, 32'h0,        1, 15'h0204, 0, 4'hF, 32'h0,        32'h11111111, 2'b10, 1, 15'h0204, 0, 4'hF, 32'h0,        2'b01, 32'h11111111, 32'h0};
    vecs[5]  = '{1, 15'h0100, 0, 4'hF, 32'h0,        1, 15'h0204, 0, 4'hF, 32'h0,        32'h22222222, 2'b01, 1, 15'h0100, 0, 4'hF, 32'h0,        2'b10, 32'h0,        32'h22222222};
    vecs[6]  = '{1, 15'h0100, 0, 4'hF, 32'h0,        1, 15'h0204, 0, 4'hF, 32'h0,        32'h33333333, 2'b10, 1, 15'h0204, 0, 4'hF, 32'h0,        2'b01, 32'h33333333, 32'h0};
    vecs[7]  = '{0, 15'h0000, 0, 4'h0, 32'h0,        0, 15'h0000, 0, 4'h0, 32'h0,        32'h44444444, 2'b00, 0, 15'h0000, 0, 4'h0, 32'h0,        2'b10, 32'h0,        32'h44444444};
    vecs[8]  = '{0, 15'h0000, 0, 4'h0, 32'h0,        1, 15'h7FFC, 1, 4'h6, 32'h11223344, 32'h0,        2'b10, 1, 15'h7FFC, 1, 4'h6, 32'h11223344, 2'b00, 32'h0,        32'h0};
    vecs[9]  = '{0, 15'h0000, 0, 4'h0, 32'h0,        0, 15'h0000, 0, 4'h0, 32'h0,        32'h55555555, 2'b00, 0, 15'h0000, 0, 4'h0, 32'h0,        2'b10, 32'h0,        32'h0};
    vecs[10] = '{1, 15'h0013, 0, 4'hF, 32'h0,        0, 15'h0000, 0, 4'h0, 32'h0,        32'h0,        2'b01, 1, 15'h0010, 0, 4'hF, 32'h0,        2'b00, 32'h0,        32'h0};
    vecs[11] = '{1, 15'h0013, 0, 4'hF, 32'h0,        0, 15'h0000, 0, 4'h0, 32'h0,        32'h00000066, 2'b01, 1, 15'h0010, 0, 4'hF, 32'h0,        2'b01, 32'h00000066, 32'h0};
    vecs[12] = '{1, 15'h0013, 0, 4'hF, 32'h0,        1, 15'h0300, 0, 4'hF, 32'h0,        32'h00000077, 2'b01, 1, 15'h0010, 0, 4'hF, 32'h0,        2'b01, 32'h00000077, 32'h0};
    vecs[13] = '{1, 15'h0013, 0, 4'hF, 32'h0,        1, 15'h0300, 0, 4'hF, 32'h0,        32'h00000088, 2'b10, 1, 15'h0300, 0, 4'hF, 32'h0,        2'b01, 32'h00000088, 32'h0};
    vecs[14] = '{1, 15'h0020, 1, 4'h1, 32'h00000099, 0, 15'h0000, 0, 4'h0, 32'h0,        32'h000000AB, 2'b01, 1, 15'h0020, 1, 4'h1, 32'h00000099, 2'b10, 32'h0,        32'h000000AB};
    vecs[15] = '{1, 15'h0040, 0, 4'hF, 32'h0,        1, 15'h0300, 0, 4'hF, 32'h0,        32'h000000CD, 2'b01, 1, 15'h0040, 0, 4'hF, 32'h0,        2'b01, 32'h0,        32'h0};
    vecs[16] = '{1, 15'h0040, 0, 4'hF, 32'h0,        1, 15'h0300, 0, 4'hF, 32'h0,        32'h000000EF, 2'b10, 1, 15'h0300, 0, 4'hF, 32'h0,        2'b01, 32'h000000EF, 32'h0};
    vecs[17] = '{0, 15'h0000, 0, 4'h0, 32'h0,        0, 15'h0000, 0, 4'h0, 32'h0,        32'h00000012, 2'b00, 0, 15'h0000, 0, 4'h0, 32'h0,        2'b10, 32'h0,        32'h00000012};

    doReset();
`ifdef SP_RAM_ARB_CLEAR_ON_RESET_EN
    m1_req_i = 1'b1; m1_addr_i = 15'h0040; m1_be_i = 4'hF;
`endif
    #2;
    checkOutput("rst_m0_rvalid", 0, 32'(m0_rvalid_o), 32'd0);
    checkOutput("rst_m1_rvalid", 0, 32'(m1_rvalid_o), 32'd0);
    checkOutput("rst_m0_gnt", 0, 32'(m0_gnt_o), 32'd0);
    checkOutput("rst_m1_gnt", 0, 32'(m1_gnt_o), 32'd0);
    checkOutput("rst_ram_en", 0, 32'(ram_en_o), 32'(CLEAR_EN));
    checkOutput("rst_init_done", 0, 32'(init_done_o), 32'(!CLEAR_EN));

`ifdef SP_RAM_ARB_CLEAR_ON_RESET_EN
    begin
      int errs = 0;
      for (int i = 0; i < 8192; i++) begin
        if (m1_gnt_o !== 1'b0 || init_done_o !== 1'b0 || ram_en_o !== 1'b1 || ram_we_o !== 1'b1 ||
            ram_be_o !== 4'hF || ram_wdata_o !== 32'h0 || ram_addr_o !== AW'(i * 4)) errs++;
        @(negedge clk);
        #2;
      end
      checkOutput("clear_seq_errs", 0, 32'(errs), 32'd0);
      checkOutput("clear_init_done", 0, 32'(init_done_o), 32'd1);
      checkOutput("clear_m1_gnt", 0, 32'(m1_gnt_o), 32'd1);
      checkOutput("clear_ram_addr", 0, 32'(ram_addr_o), 32'h40);
      @(negedge clk);
      idleInputs();
      #2;
      checkOutput("clear_m1_rvalid", 0, 32'(m1_rvalid_o), 32'd1);
    end
`endif
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput("gnt", i, 32'({m1_gnt_o, m0_gnt_o}), 32'(vecs[i].gnt));
      checkOutput("ram_en", i, 32'(ram_en_o), 32'(vecs[i].en));
      checkOutput("ram_addr", i, 32'(ram_addr_o), 32'(vecs[i].addr));
      checkOutput("ram_we", i, 32'(ram_we_o), 32'(vecs[i].we));
      checkOutput("ram_be", i, 32'(ram_be_o), 32'(vecs[i].be));
      checkOutput("ram_wdata", i, ram_wdata_o, vecs[i].wdata);
      checkOutput("rvalid", i, 32'({m1_rvalid_o, m0_rvalid_o}), 32'(vecs[i].rvalid));
      checkOutput("m0_rdata", i, m0_rdata_o, vecs[i].r0);
      checkOutput("m1_rdata", i, m1_rdata_o, vecs[i].r1);
      @(negedge clk);
    end

    // Reset one cycle after a grant: the pending response must vanish.
    idleInputs();
    m0_req_i = 1'b1; m0_addr_i = 15'h0010; m0_be_i = 4'hF;
    ram_rdata_i = 32'hCAFEF00D;
    #2;
    checkOutput("pre_rst_gnt", 0, 32'(m0_gnt_o), 32'd1);
    @(negedge clk);
    rstn_i = 1'b0;
    #2;
    checkOutput("in_rst_m0_rvalid", 0, 32'(m0_rvalid_o), 32'd0);
    checkOutput("in_rst_m0_rdata", 0, m0_rdata_o, 32'h0);
    checkOutput("in_rst_m0_gnt", 0, 32'(m0_gnt_o), 32'd0);
    checkOutput("in_rst_ram_en", 0, 32'(ram_en_o), 32'd0);
    checkOutput("in_rst_init_done", 0, 32'(init_done_o), 32'd0);
    @(negedge clk);
    m0_req_i = 1'b0;
    rstn_i = 1'b1;
    #1;
    checkOutput("post_rst_m0_rvalid", 0, 32'(m0_rvalid_o), 32'd0);
    waitReady();
    for (int i = 0; i < 3; i++) begin
      #2;
      checkOutput("stale_m0_rvalid", i, 32'(m0_rvalid_o), 32'd0);
      checkOutput("stale_m1_rvalid", i, 32'(m1_rvalid_o), 32'd0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
